seq_mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 32-bit signed sequential (shift-add) multiplier between NUM_REQ requesters. It accepts one operand pair at a time over a valid/ready handshake and drives the multiplier's load/operand inputs. It counts out the multiplier's fixed latency, then returns the 64-bit product tagged with the requester ID over a valid/ready response port. Only one operation is in flight at a time.

---
 rtl/seq_mult_arbiter.sv | 124 ++++++++++++
 tb/tb_seq_mult_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_arbiter.sv
// Round-robin front end sharing one sequential signed multiplier between NUM_REQ requesters.
// One operation is in flight at a time; the product returns tagged with the owner's index.
module seq_mult_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 33
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]       rsp_product,
    output logic                     mul_load,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic [2*WIDTH-1:0]       mul_product
);
    localparam int CNT_W = $clog2(MUL_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, LOAD, BUSY, RESP} state_t;

    state_t               state_q;
    logic [ID_W-1:0]      rr_ptr_q;
    logic [ID_W-1:0]      rr_ptr_d;
    logic [CNT_W-1:0]     cnt_q;
    logic                 rsp_valid_q;
    logic [ID_W-1:0]      rsp_id_q;
    logic [2*WIDTH-1:0]   rsp_product_q;
    logic                 mul_load_q;
    logic [WIDTH-1:0]     mul_a_q;
    logic [WIDTH-1:0]     mul_b_q;

    logic                 grant_found;
    logic [ID_W-1:0]      grant_idx;
    logic                 grant_fire;
    logic [WIDTH-1:0]     a_slice [NUM_REQ];
    logic [WIDTH-1:0]     b_slice [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_slice[gi] = req_a[gi*WIDTH +: WIDTH];
            assign b_slice[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // First asserted request at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            end
        end
        rr_ptr_d = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
    end

    assign req_ready  = (state_q == IDLE && grant_found && !reset)
                      ? (NUM_REQ'(1) << grant_idx) : '0;
    assign grant_fire = |req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_product_q <= '0;
            mul_load_q    <= 1'b0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_fire) begin
                        mul_a_q    <= a_slice[grant_idx];
                        mul_b_q    <= b_slice[grant_idx];
                        rsp_id_q   <= grant_idx;
                        rr_ptr_q   <= rr_ptr_d;
                        mul_load_q <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    mul_load_q <= 1'b0;
                    cnt_q      <= '0;
                    state_q    <= BUSY;
                end
                BUSY: begin
                    // Operands stay put: the multiplier re-reads the sign of a at the end.
                    if (cnt_q == CNT_W'(MUL_LATENCY)) begin
                        rsp_product_q <= mul_product;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_product = rsp_product_q;
    assign mul_load    = mul_load_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
endmodule

// File: tb/tb_seq_mult_arbiter.sv
// Randomized and directed bench for seq_mult_arbiter with a transaction-level reference model
// and a behavioural sequential multiplier that only produces its result after MUL_LATENCY edges.
module tb_seq_mult_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int WIDTH   = 32;
    localparam int LAT     = 33;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [2*WIDTH-1:0]       rsp_product;
    logic                     mul_load;
    logic [WIDTH-1:0]         mul_a;
    logic [WIDTH-1:0]         mul_b;
    logic [2*WIDTH-1:0]       mul_product;

    always #5 clk = ~clk;

    seq_mult_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .WIDTH(WIDTH), .MUL_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_product(rsp_product),
        .mul_load(mul_load), .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product)
    );

    function automatic logic [63:0] prod(logic [31:0] a, logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    // Multiplier stand-in: garbage until the product register is written LAT edges after load.
    int          mul_rem = 0;
    logic [63:0] mul_reg = 64'h0BAD_0BAD_0BAD_0BAD;
    assign mul_product = mul_reg;
    always @(posedge clk) begin
        if (mul_load === 1'b1) begin
            mul_rem <= LAT;
            mul_reg <= 64'h0BAD_0BAD_0BAD_0BAD;
        end else if (mul_rem > 0) begin
            mul_rem <= mul_rem - 1;
            if (mul_rem == 1) mul_reg <= prod(mul_a, mul_b);
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [NUM_REQ-1:0] pend = '0;
    logic [WIDTH-1:0]   op_a [NUM_REQ];
    logic [WIDTH-1:0]   op_b [NUM_REQ];
    int                 ptr = 0;
    int                 cyc = 0;
    int                 grant_cyc = -100;
    int                 due = 0;
    int                 hs_cyc = 0;
    bit                 busy = 0;
    bit                 outst = 0;
    int                 exp_id = 0;
    logic [WIDTH-1:0]   exp_a;
    logic [WIDTH-1:0]   exp_b;
    logic [63:0]        exp_prod;
    int                 grant_log [$];

    task automatic drive();
        req_valid = pend;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = op_a[i];
            req_b[i*WIDTH +: WIDTH] = op_b[i];
        end
    endtask

    task automatic step();
        logic [NUM_REQ-1:0] exp_rdy;
        int g;
        bit exp_load;
        bit rsp_due;
        drive();
        #1;
        cyc++;
        exp_rdy = '0;
        g = -1;
        if (!busy) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (g < 0 && pend[(ptr + i) % NUM_REQ]) g = (ptr + i) % NUM_REQ;
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        for (int i = 0; i < NUM_REQ; i++)
            if (req_valid[i] && req_ready[i]) grant_log.push_back(i);
        exp_load = outst && (cyc == grant_cyc + 1);
        chk("mul_load", mul_load, exp_load);
        if (exp_load) begin
            chk("mul_a", mul_a, exp_a);
            chk("mul_b", mul_b, exp_b);
        end
        rsp_due = outst && (cyc >= due);
        chk("rsp_valid", rsp_valid, rsp_due);
        if (rsp_due) begin
            chk("rsp_id", rsp_id, exp_id);
            chk("rsp_product", rsp_product, exp_prod);
            if (rsp_ready) begin
                outst  = 0;
                busy   = 0;
                hs_cyc = cyc;
                $display("rsp id=%0d a=%h b=%h product=%h grant_cycle=%0d rsp_cycle=%0d",
                         exp_id, exp_a, exp_b, rsp_product, grant_cyc, cyc);
            end
        end
        if (g >= 0) begin
            busy      = 1;
            outst     = 1;
            grant_cyc = cyc;
            due       = cyc + LAT + 3;
            exp_id    = g;
            exp_a     = op_a[g];
            exp_b     = op_b[g];
            exp_prod  = prod(op_a[g], op_b[g]);
            ptr       = (g + 1) % NUM_REQ;
            pend[g]   = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive();
        @(negedge clk);
        #1;
        cyc++;
        chk("rst_req_ready", req_ready, '0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_product", rsp_product, 0);
        chk("rst_mul_load", mul_load, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        reset = 1'b0;
        busy  = 0;
        outst = 0;
        ptr   = 0;
        grant_cyc = -100;
    endtask

    task automatic run_idle(string tag, int budget);
        step();
        for (int n = 0; n < budget && (outst || pend != '0); n++) step();
        if (outst || pend != '0) chk({tag, "_timeout"}, 1, 0);
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic one_op(int r, logic [31:0] a, logic [31:0] b, string tag);
        op_a[r] = a;
        op_b[r] = b;
        pend[r] = 1'b1;
        run_idle(tag, 200);
    endtask

    logic [ID_W-1:0]    snap_id;
    logic [63:0]        snap_prod;
    int                 exp_order [7] = '{0, 1, 2, 3, 0, 1, 3};

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        rsp_ready = 1'b0;
        do_reset();

        // Single request, 7 * -3
        rsp_ready = 1'b1;
        one_op(0, 32'd7, -32'sd3, "t1");
        chk("t1_latency", hs_cyc - grant_cyc, LAT + 3);
        chk("t1_product", exp_prod, 64'hFFFF_FFFF_FFFF_FFEB);

        // Round-robin order and per-requester products
        do_reset();
        grant_log.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            op_a[i] = i + 1;
            op_b[i] = 100;
        end
        pend = '1;
        run_idle("t2a", 400);
        pend[0] = 1'b1;
        run_idle("t2b", 200);
        pend[1] = 1'b1;
        pend[3] = 1'b1;
        run_idle("t2c", 300);
        chk("t2_count", grant_log.size(), 7);
        for (int i = 0; i < 7 && i < grant_log.size(); i++)
            chk("t2_order", grant_log[i], exp_order[i]);

        // Response back-pressure
        op_a[1] = 32'd12345;
        op_b[1] = -32'sd77;
        pend[1] = 1'b1;
        rsp_ready = 1'b0;
        step();
        for (int n = 0; n < 100 && !(outst && cyc >= due); n++) step();
        chk("t3_reached_rsp", outst && (cyc >= due), 1);
        snap_id   = rsp_id;
        snap_prod = rsp_product;
        op_a[2] = 32'd3;
        op_b[2] = 32'd4;
        pend[2] = 1'b1;
        repeat (10) step();
        chk("t3_hold_id", rsp_id, snap_id);
        chk("t3_hold_product", rsp_product, snap_prod);
        rsp_ready = 1'b1;
        step();
        step();
        chk("t3_grant_after_stall", grant_cyc, hs_cyc + 1);
        run_idle("t3", 200);

        // Corner operands
        one_op(3, 32'h8000_0000, 32'hFFFF_FFFF, "t4a");
        chk("t4a_product", exp_prod, 64'h0000_0000_8000_0000);
        one_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "t4b");
        one_op(1, 32'h0000_0000, 32'h7FFF_FFFF, "t4c");

        // Reset while the multiplier is busy
        do_reset();
        op_a[0] = 32'd9;
        op_b[0] = 32'd9;
        pend[0] = 1'b1;
        step();
        for (int n = 0; n < 50 && cyc < grant_cyc + 11; n++) step();
        do_reset();
        repeat (50) step();
        one_op(0, 32'd5, 32'd6, "t5");
        chk("t5_latency", hs_cyc - grant_cyc, LAT + 3);

        // Request arriving while another is in flight
        grant_log.delete();
        op_a[1] = -32'sd1000;
        op_b[1] = 32'd3;
        pend[1] = 1'b1;
        step();
        for (int n = 0; n < 20 && !(outst && cyc >= grant_cyc + 5); n++) step();
        op_a[2] = 32'd11;
        op_b[2] = -32'sd11;
        pend[2] = 1'b1;
        run_idle("t6", 200);
        chk("t6_count", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("t6_first", grant_log[0], 1);
            chk("t6_second", grant_log[1], 2);
        end

        // Randomized traffic
        repeat (1500) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 7) == 0) begin
                    op_a[i] = rand_op();
                    op_b[i] = rand_op();
                    pend[i] = 1'b1;
                end
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        rsp_ready = 1'b1;
        run_idle("rand_drain", 400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
